// File: rtl/vga_line_arbiter.sv
// Line-buffer arbiter between a VGA scan-out reader and a pixel writer sharing one
// single-port line RAM, with double-banked lines swapped on odd VGA lines.
module vga_line_arbiter #(
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned PIX_SHIFT = 2,
  parameter int unsigned H_SWAP    = 799
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [6:0] wr_data,
  input  logic       wr_line_done,
  output logic       wr_ack,
  output logic       ram_en,
  output logic       ram_we,
  output logic [8:0] ram_addr,
  output logic [6:0] ram_wdata,
  input  logic [6:0] ram_rdata,
  output logic [6:0] pix_color,
  output logic       miss,
  output logic [7:0] miss_count
);

  typedef enum logic {StFill, StReady} state_t;

  // The pixel index field of the RAM address is 8 bits wide.
  if ((H_DISPLAY >> PIX_SHIFT) > 256) begin : g_bad_geometry
    $error("vga_line_arbiter: H_DISPLAY >> PIX_SHIFT exceeds 256 source pixels");
  end

  state_t     r_state;
  logic       r_rd_bank;
  logic       r_miss;
  logic [7:0] r_miss_count;
  logic       r_slot_q;
  logic       r_off_q;
  logic [6:0] r_pix_color;

  logic       w_read_slot;
  logic       w_swap;
  logic [7:0] w_rd_idx;
  logic       w_unused_vpos;

  assign w_read_slot   = display_on && (hpos[PIX_SHIFT-1:0] == '0);
  assign w_swap        = (hpos == 10'(H_SWAP)) && vpos[0];
  assign w_rd_idx      = 8'(hpos >> PIX_SHIFT);
  assign w_unused_vpos = ^vpos[9:1];

  // Reader owns the RAM on its slot; the writer fills any other cycle.
  assign wr_ack    = wr_req && !w_read_slot;
  assign ram_en    = w_read_slot || wr_req;
  assign ram_we    = wr_ack;
  assign ram_addr  = w_read_slot ? {r_rd_bank, w_rd_idx} : {~r_rd_bank, wr_addr};
  assign ram_wdata = wr_data;

  assign pix_color  = r_pix_color;
  assign miss       = r_miss;
  assign miss_count = r_miss_count;

  // Pixel pipeline: RAM data arrives the cycle after the slot and is captured then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_q    <= 1'b0;
      r_off_q     <= 1'b0;
      r_pix_color <= '0;
    end else begin
      r_slot_q <= w_read_slot;
      r_off_q  <= !display_on;
      if (r_slot_q) begin
        r_pix_color <= ram_rdata;
      end else if (r_off_q) begin
        r_pix_color <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StFill;
      r_rd_bank    <= 1'b0;
      r_miss       <= 1'b0;
      r_miss_count <= '0;
    end else begin
      r_miss <= 1'b0;
      unique case (r_state)
        StFill: begin
          if (w_swap && wr_line_done) begin
            r_rd_bank <= ~r_rd_bank;
          end else if (w_swap) begin
            // Line not ready: keep showing the old bank and record the miss.
            r_miss <= 1'b1;
            if (r_miss_count != 8'hFF) begin
              r_miss_count <= r_miss_count + 8'd1;
            end
          end else if (wr_line_done) begin
            r_state <= StReady;
          end
        end
        StReady: begin
          if (w_swap) begin
            r_rd_bank <= ~r_rd_bank;
            r_state   <= StFill;
          end
        end
        default: r_state <= StFill;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_line_arbiter.sv
// Directed self-checking bench for vga_line_arbiter with a behavioural line RAM.
module tb_vga_line_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [6:0] wr_data;
  logic       wr_line_done;
  logic       wr_ack;
  logic       ram_en;
  logic       ram_we;
  logic [8:0] ram_addr;
  logic [6:0] ram_wdata;
  logic [6:0] ram_rdata;
  logic [6:0] pix_color;
  logic       miss;
  logic [7:0] miss_count;

  int tests = 0;
  int failures = 0;

  logic [6:0] mem [512];

  always #5 clk = ~clk;

  vga_line_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hpos         (hpos),
    .vpos         (vpos),
    .display_on   (display_on),
    .wr_req       (wr_req),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_line_done (wr_line_done),
    .wr_ack       (wr_ack),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .pix_color    (pix_color),
    .miss         (miss),
    .miss_count   (miss_count)
  );

  // Single-port synchronous RAM, one-cycle read latency.
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    ram_rdata = '0;
  end

  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; hpos = 10'd0; vpos = 10'd0; display_on = 1'b1;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_line_done = 1'b0;
    #1;
    check("rst_pix", pix_color, 0);
    check("rst_miss", miss, 0);
    check("rst_miss_count", miss_count, 0);
    check("rst_read_addr", ram_addr, 9'h000);
    check("rst_read_en", {ram_en, ram_we}, 2'b10);
    tick(); tick();
    rst_n = 1'b1;
    display_on = 1'b0; hpos = 10'd700;
    tick();

    // Fill back bank 1.
    wr_req = 1'b1; wr_addr = 8'd0; wr_data = 7'h11; #1;
    check("wr0_ack", wr_ack, 1);
    check("wr0_we", ram_we, 1);
    check("wr0_addr", ram_addr, 9'h100);
    tick();
    wr_addr = 8'd1; wr_data = 7'h22; tick();
    wr_addr = 8'd200; wr_data = 7'h33; #1;
    check("wr_oob_addr", ram_addr, 9'h1C8);
    check("wr_oob_data", ram_wdata, 7'h33);
    tick();
    wr_req = 1'b0; #1;
    check("idle_en_we", {ram_en, ram_we, wr_ack}, 3'b000);

    // Complete line then swap.
    wr_line_done = 1'b1; tick();
    wr_line_done = 1'b0; hpos = 10'd799; vpos = 10'd1; tick();
    check("swap1_no_miss", miss, 0);
    vpos = 10'd0;

    // Read timing across hpos 0..7, with a write colliding at hpos 4.
    display_on = 1'b1;
    for (int h = 0; h < 8; h++) begin
      hpos = 10'(h);
      wr_req = (h == 4 || h == 5);
      wr_addr = 8'd5; wr_data = 7'h55;
      #1;
      if (h == 0) check("rd_addr_h0", ram_addr, 9'd256);
      if (h == 0) check("rd_en_h0", {ram_en, ram_we}, 2'b10);
      if (h == 4) check("rd_addr_h4", ram_addr, 9'd257);
      if (h == 4) check("coll_h4", {wr_ack, ram_we}, 2'b00);
      if (h == 5) check("coll_h5", {wr_ack, ram_we, ram_addr[8]}, 3'b110);
      if (h < 2) check($sformatf("pix_h%0d", h), pix_color, 0);
      else if (h < 6) check($sformatf("pix_h%0d", h), pix_color, 7'h11);
      else check($sformatf("pix_h%0d", h), pix_color, 7'h22);
      tick();
    end
    wr_req = 1'b0;
    display_on = 1'b0; hpos = 10'd8; tick();
    hpos = 10'd9; #1;
    check("pix_hold_off", pix_color, 7'h22);
    tick();
    hpos = 10'd10; #1;
    check("pix_blank", pix_color, 0);
    check("bank0_written", mem[5], 7'h55);

    // No swap on even vpos.
    wr_line_done = 1'b1; tick();
    wr_line_done = 1'b0; hpos = 10'd799; vpos = 10'd2; tick();
    display_on = 1'b1; hpos = 10'd0; vpos = 10'd0; #1;
    check("noswap_even_bank", ram_addr[8], 1);
    check("noswap_even_miss", miss, 0);
    display_on = 1'b0; hpos = 10'd799; vpos = 10'd1; tick();
    display_on = 1'b1; hpos = 10'd0; vpos = 10'd0; #1;
    check("swap2_bank", ram_addr[8], 0);
    check("swap2_no_miss", miss, 0);
    display_on = 1'b0;

    // Miss: now in FILL with no line done.
    hpos = 10'd799; vpos = 10'd1; tick();
    check("miss_pulse", miss, 1);
    check("miss_count1", miss_count, 1);
    hpos = 10'd0; vpos = 10'd0; tick();
    check("miss_clear", miss, 0);
    display_on = 1'b1; #1;
    check("miss_bank_kept", ram_addr[8], 0);
    display_on = 1'b0;

    // Coincident line done and swap in FILL.
    hpos = 10'd799; vpos = 10'd1; wr_line_done = 1'b1; tick();
    wr_line_done = 1'b0;
    check("coinc_no_miss", miss, 0);
    check("coinc_count", miss_count, 1);
    hpos = 10'd0; vpos = 10'd0; display_on = 1'b1; #1;
    check("coinc_bank", ram_addr[8], 1);
    display_on = 1'b0;

    // Saturation.
    hpos = 10'd799; vpos = 10'd1;
    repeat (300) tick();
    check("miss_sat", miss_count, 8'd255);
    hpos = 10'd0; vpos = 10'd0; display_on = 1'b1; #1;
    check("sat_bank_kept", ram_addr[8], 1);
    display_on = 1'b0;

    // Build up READY, bank 1, miss_count 5, nonzero pixel; then async reset.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    wr_line_done = 1'b1; tick();
    wr_line_done = 1'b0; hpos = 10'd799; vpos = 10'd1; tick();
    repeat (5) tick();
    hpos = 10'd0; vpos = 10'd0; wr_line_done = 1'b1; tick();
    wr_line_done = 1'b0;
    check("pre_rst_count", miss_count, 5);
    display_on = 1'b1; tick(); tick();
    hpos = 10'd1; tick();
    check("pre_rst_pix", pix_color, 7'h11);
    hpos = 10'd0; #2;
    rst_n = 1'b0; #1;
    check("arst_count", miss_count, 0);
    check("arst_pix", pix_color, 0);
    check("arst_bank", ram_addr[8], 0);
    tick();
    rst_n = 1'b1; display_on = 1'b0; tick();
    hpos = 10'd799; vpos = 10'd1; tick();
    check("arst_fill_state", miss, 1);
    check("arst_fill_count", miss_count, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
